id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 i_Clk_1  in  1  sole clock, rising edge.
REQ-002 i_RstN_1  in  1  reset, asynchronous, active-low.
REQ-003 i_InstrValid_1 / o_InstrReady_1  in/out  1/1  upstream (fetch) handshake; transfer when both high at a rising edge.
REQ-004 i_Instr_32, i_PC_32  in  32/32  instruction word and its PC.
REQ-005 o_RS1Addr_5, o_RS2Addr_5  out  5/5  combinational from i_Instr_32[19:15]/[24:20]; i_RS1Data_32, i_RS2Data_32 (in, 32) return same cycle.
REQ-006 i_Flush_1  in  1  kill held and incoming instruction.
REQ-007 o_DecValid_1 / i_DecReady_1  out/in  1/1  downstream (execute) handshake.
REQ-008 o_PC_32, o_ALUControl_12, o_ALUOperand1_32, o_ALUOperand2_32  out  registered ALU inputs.
REQ-009 o_RS1Value_32, o_RS2Value_32  out  32/32  raw register values (branch compare, store data).
REQ-010 o_RdAddr_5, o_RegWrite_1, o_MemRead_1, o_MemWrite_1, o_Funct3_3, o_Branch_1, o_Jump_1, o_Illegal_1  out  registered control.

Function
REQ-011 o_ALUControl_12 SHALL be one-hot or zero, bit order [11]ADD [10]PC4 [9]SUB [8]SLT [7]SLTU [6]AND [5]OR [4]XOR [3]SLL [2]SRL [1]SRA [0]LUI.
REQ-012 OP/OP-IMM SHALL map funct3/funct7[5] to ADD/SUB/SLT/SLTU/AND/OR/XOR/SLL/SRL/SRA; op1=rs1, op2=rs2 or sign-extended immI; SUB only for OP.
REQ-013 Shifts SHALL drive op2 = {27'b0, amount[4:0]} (downstream shifts by full 32-bit op2).
REQ-014 LUI: LUI, op2=immU. AUIPC: ADD, op1=PC, op2=immU.
REQ-015 JAL: PC4, op1=PC, op2=immJ, o_Jump_1=1. JALR: PC4, op1=rs1, op2=immI, o_Jump_1=1 (target LSB clearing is downstream).
REQ-016 BRANCH: ALUControl=0, op1=PC, op2=immB, o_Branch_1=1, o_RegWrite_1=0 (adder yields target).
REQ-017 LOAD: ADD, op1=rs1, op2=immI, o_MemRead_1=1. STORE: ADD, op1=rs1, op2=immS, o_MemWrite_1=1, o_RegWrite_1=0.
REQ-018 o_Funct3_3 SHALL carry i_Instr_32[14:12] for all opcodes.
REQ-019 o_RegWrite_1 SHALL be 0 when rd=0.
REQ-020 Unknown opcode, invalid funct3/funct7 combination, or instr[1:0]!=2'b11 SHALL set o_Illegal_1=1, ALUControl=0, RegWrite/MemRead/MemWrite/Branch/Jump=0.
REQ-021 Latency one cycle: instruction accepted at edge N appears with o_DecValid_1=1 after edge N.
REQ-022 o_InstrReady_1 = ~o_DecValid_1 | i_DecReady_1 (combinational); full throughput 1 instr/cycle.
REQ-023 With o_DecValid_1=1 and i_DecReady_1=0, all outputs SHALL hold stable.
REQ-024 Simultaneous downstream accept and upstream transfer SHALL load the new instruction, o_DecValid_1 stays 1.
REQ-025 Downstream accept without upstream transfer SHALL clear o_DecValid_1.
REQ-026 i_Flush_1=1 SHALL clear o_DecValid_1 at next edge, overriding any simultaneous capture; o_InstrReady_1 unaffected.

Reset
REQ-027 On i_RstN_1 low, o_DecValid_1 and every registered output SHALL go to 0 immediately, irrespective of clock.
REQ-028 Reset mid-stall SHALL discard the held instruction; first accept after deassertion is a normal transfer.

Structure
REQ-029 Opcode constants, funct3 codes and ALU-control bit indices SHALL live in shared package rv32i_pkg.
REQ-030 Immediate generation (I/S/B/U/J, sign extension) SHALL be sub-module imm_gen; decode control and pipeline register in id_stage.

Verification
REQ-031 Reset: assert i_RstN_1 mid-stall with valid held -> o_DecValid_1=0 and ALUControl=12'h000 without clock edge.
REQ-032 ADDI x5,x1,-1 (0xFFF08293), rs1=32'h10 -> ALUControl=12'h800, op1=32'h10, op2=32'hFFFFFFFF, RdAddr=5, RegWrite=1 one cycle later.
REQ-033 SRAI x3,x2,4 (0x40415193) -> ALUControl=12'h002, op2=32'h4; SUB x1,x2,x3 (0x403100B3) -> 12'h200.
REQ-034 JAL x1,+8 (0x008000EF) at PC=32'h100 -> ALUControl=12'h400, op1=32'h100, op2=32'h8, Jump=1; BEQ at PC 32'h200, offset -4 -> ALUControl=0, op2=32'hFFFFFFFC, Branch=1.
REQ-035 Stall: i_DecReady_1=0 for 3 cycles with new valid input -> o_InstrReady_1=0, outputs unchanged; release -> next instr loaded same edge, no loss or duplicate.
REQ-036 Flush with i_InstrValid_1=1 same cycle -> o_DecValid_1=0 next cycle; 32'h00000000 input -> o_Illegal_1=1, all enables 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcode/funct encodings, ALU one-hot bit positions and the
// decode-stage pipeline record shared by the decode logic.
package rv32i_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Bit positions inside the 12-bit one-hot ALU control word
   localparam int unsigned ALU_ADD  = 11;
   localparam int unsigned ALU_PC4  = 10;
   localparam int unsigned ALU_SUB  = 9;
   localparam int unsigned ALU_SLT  = 8;
   localparam int unsigned ALU_SLTU = 7;
   localparam int unsigned ALU_AND  = 6;
   localparam int unsigned ALU_OR   = 5;
   localparam int unsigned ALU_XOR  = 4;
   localparam int unsigned ALU_SLL  = 3;
   localparam int unsigned ALU_SRL  = 2;
   localparam int unsigned ALU_SRA  = 1;
   localparam int unsigned ALU_LUI  = 0;

   typedef enum logic [1:0] {
      OP1_ZERO,
      OP1_RS1,
      OP1_PC
   } op1_sel_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [11:0] alu_ctrl;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  funct3;
      logic        branch;
      logic        jump;
      logic        illegal;
   } dec_t;

   function automatic logic [11:0] alu_onehot(input int unsigned idx);
      return 12'd1 << idx;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended I/S/B/U/J immediates from the instruction word.
// The opcode bits carry no immediate information, so only [31:7] is taken.
module imm_gen (
   input  logic [31:7] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage. Decodes one instruction per cycle into a
// one-hot ALU control word, ALU operands and control enables, held in a
// single valid/ready pipeline register towards execute.
module id_stage
   import rv32i_pkg::*;
(
   input  logic        i_Clk_1,
   input  logic        i_RstN_1,
   input  logic        i_InstrValid_1,
   output logic        o_InstrReady_1,
   input  logic [31:0] i_Instr_32,
   input  logic [31:0] i_PC_32,
   output logic [4:0]  o_RS1Addr_5,
   output logic [4:0]  o_RS2Addr_5,
   input  logic [31:0] i_RS1Data_32,
   input  logic [31:0] i_RS2Data_32,
   input  logic        i_Flush_1,
   output logic        o_DecValid_1,
   input  logic        i_DecReady_1,
   output logic [31:0] o_PC_32,
   output logic [11:0] o_ALUControl_12,
   output logic [31:0] o_ALUOperand1_32,
   output logic [31:0] o_ALUOperand2_32,
   output logic [31:0] o_RS1Value_32,
   output logic [31:0] o_RS2Value_32,
   output logic [4:0]  o_RdAddr_5,
   output logic        o_RegWrite_1,
   output logic        o_MemRead_1,
   output logic        o_MemWrite_1,
   output logic [2:0]  o_Funct3_3,
   output logic        o_Branch_1,
   output logic        o_Jump_1,
   output logic        o_Illegal_1
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic        f7_base;
   logic        f7_alt;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] shamt_reg, shamt_imm;

   op1_sel_t    op1_sel;
   logic [11:0] alu;
   logic [31:0] op2;
   logic        reg_write, mem_read, mem_write, branch, jump, illegal;

   dec_t        dec_d, dec_q;
   logic        dec_valid;
   logic        capture;

   assign opcode      = i_Instr_32[6:0];
   assign rd          = i_Instr_32[11:7];
   assign funct3      = i_Instr_32[14:12];
   assign funct7      = i_Instr_32[31:25];
   assign f7_base     = (funct7 == F7_BASE);
   assign f7_alt      = (funct7 == F7_ALT);
   assign o_RS1Addr_5 = i_Instr_32[19:15];
   assign o_RS2Addr_5 = i_Instr_32[24:20];
   assign shamt_reg   = {27'b0, i_RS2Data_32[4:0]};
   assign shamt_imm   = {27'b0, i_Instr_32[24:20]};

   imm_gen u_imm_gen (
      .instr (i_Instr_32[31:7]),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j)
   );

   // Opcode/funct decode into ALU one-hot, operand selection and control enables
   always_comb begin
      alu       = '0;
      op1_sel   = OP1_ZERO;
      op2       = '0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      illegal   = 1'b0;
      if (i_Instr_32[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (opcode)
            OPC_OP: begin
               op1_sel   = OP1_RS1;
               op2       = i_RS2Data_32;
               reg_write = 1'b1;
               case (funct3)
                  F3_ADD:  if (f7_base) alu = alu_onehot(ALU_ADD);
                           else if (f7_alt) alu = alu_onehot(ALU_SUB);
                           else illegal = 1'b1;
                  F3_SLL:  begin
                              op2 = shamt_reg;
                              if (f7_base) alu = alu_onehot(ALU_SLL); else illegal = 1'b1;
                           end
                  F3_SLT:  if (f7_base) alu = alu_onehot(ALU_SLT);  else illegal = 1'b1;
                  F3_SLTU: if (f7_base) alu = alu_onehot(ALU_SLTU); else illegal = 1'b1;
                  F3_XOR:  if (f7_base) alu = alu_onehot(ALU_XOR);  else illegal = 1'b1;
                  F3_SR:   begin
                              op2 = shamt_reg;
                              if (f7_base) alu = alu_onehot(ALU_SRL);
                              else if (f7_alt) alu = alu_onehot(ALU_SRA);
                              else illegal = 1'b1;
                           end
                  F3_OR:   if (f7_base) alu = alu_onehot(ALU_OR);   else illegal = 1'b1;
                  default: if (f7_base) alu = alu_onehot(ALU_AND);  else illegal = 1'b1;
               endcase
            end
            OPC_OP_IMM: begin
               op1_sel   = OP1_RS1;
               op2       = imm_i;
               reg_write = 1'b1;
               case (funct3)
                  F3_ADD:  alu = alu_onehot(ALU_ADD);
                  F3_SLL:  begin
                              op2 = shamt_imm;
                              if (f7_base) alu = alu_onehot(ALU_SLL); else illegal = 1'b1;
                           end
                  F3_SLT:  alu = alu_onehot(ALU_SLT);
                  F3_SLTU: alu = alu_onehot(ALU_SLTU);
                  F3_XOR:  alu = alu_onehot(ALU_XOR);
                  F3_SR:   begin
                              op2 = shamt_imm;
                              if (f7_base) alu = alu_onehot(ALU_SRL);
                              else if (f7_alt) alu = alu_onehot(ALU_SRA);
                              else illegal = 1'b1;
                           end
                  F3_OR:   alu = alu_onehot(ALU_OR);
                  default: alu = alu_onehot(ALU_AND);
               endcase
            end
            OPC_LUI: begin
               alu       = alu_onehot(ALU_LUI);
               op2       = imm_u;
               reg_write = 1'b1;
            end
            OPC_AUIPC: begin
               alu       = alu_onehot(ALU_ADD);
               op1_sel   = OP1_PC;
               op2       = imm_u;
               reg_write = 1'b1;
            end
            OPC_JAL: begin
               alu       = alu_onehot(ALU_PC4);
               op1_sel   = OP1_PC;
               op2       = imm_j;
               reg_write = 1'b1;
               jump      = 1'b1;
            end
            OPC_JALR: begin
               alu       = alu_onehot(ALU_PC4);
               op1_sel   = OP1_RS1;
               op2       = imm_i;
               reg_write = 1'b1;
               jump      = 1'b1;
               if (funct3 != F3_ADD) illegal = 1'b1;
            end
            OPC_BRANCH: begin
               op1_sel = OP1_PC;
               op2     = imm_b;
               branch  = 1'b1;
               if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
            end
            OPC_LOAD: begin
               alu       = alu_onehot(ALU_ADD);
               op1_sel   = OP1_RS1;
               op2       = imm_i;
               reg_write = 1'b1;
               mem_read  = 1'b1;
               if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
            end
            OPC_STORE: begin
               alu       = alu_onehot(ALU_ADD);
               op1_sel   = OP1_RS1;
               op2       = imm_s;
               mem_write = 1'b1;
               if (funct3[2] || funct3 == 3'b011) illegal = 1'b1;
            end
            default: illegal = 1'b1;
         endcase
      end
      // Illegal encodings must not leave any side-effect enable asserted
      if (illegal) begin
         alu       = '0;
         reg_write = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         branch    = 1'b0;
         jump      = 1'b0;
      end
      if (rd == 5'd0) reg_write = 1'b0;
   end

   // Operand-1 mux and assembly of the next pipeline-register contents
   always_comb begin
      dec_d = '0;
      case (op1_sel)
         OP1_RS1: dec_d.op1 = i_RS1Data_32;
         OP1_PC:  dec_d.op1 = i_PC_32;
         default: dec_d.op1 = '0;
      endcase
      dec_d.pc        = i_PC_32;
      dec_d.alu_ctrl  = alu;
      dec_d.op2       = op2;
      dec_d.rs1_val   = i_RS1Data_32;
      dec_d.rs2_val   = i_RS2Data_32;
      dec_d.rd        = rd;
      dec_d.reg_write = reg_write;
      dec_d.mem_read  = mem_read;
      dec_d.mem_write = mem_write;
      dec_d.funct3    = funct3;
      dec_d.branch    = branch;
      dec_d.jump      = jump;
      dec_d.illegal   = illegal;
   end

   assign o_InstrReady_1 = ~dec_valid | i_DecReady_1;
   assign capture        = i_InstrValid_1 & o_InstrReady_1;

   // Pipeline register: flush beats capture, capture beats drain, else hold
   always_ff @(posedge i_Clk_1 or negedge i_RstN_1) begin
      if (!i_RstN_1) begin
         dec_valid <= 1'b0;
         dec_q     <= '0;
      end else if (i_Flush_1) begin
         dec_valid <= 1'b0;
      end else if (capture) begin
         dec_valid <= 1'b1;
         dec_q     <= dec_d;
      end else if (i_DecReady_1) begin
         dec_valid <= 1'b0;
      end
   end

   assign o_DecValid_1     = dec_valid;
   assign o_PC_32          = dec_q.pc;
   assign o_ALUControl_12  = dec_q.alu_ctrl;
   assign o_ALUOperand1_32 = dec_q.op1;
   assign o_ALUOperand2_32 = dec_q.op2;
   assign o_RS1Value_32    = dec_q.rs1_val;
   assign o_RS2Value_32    = dec_q.rs2_val;
   assign o_RdAddr_5       = dec_q.rd;
   assign o_RegWrite_1     = dec_q.reg_write;
   assign o_MemRead_1      = dec_q.mem_read;
   assign o_MemWrite_1     = dec_q.mem_write;
   assign o_Funct3_3       = dec_q.funct3;
   assign o_Branch_1       = dec_q.branch;
   assign o_Jump_1         = dec_q.jump;
   assign o_Illegal_1      = dec_q.illegal;

endmodule
